// File: rtl/fp64_result_packer_pkg.sv
// Shared FP64 packing constants, rounding-mode / flag encodings and record types.
package fp64_result_packer_pkg;

  localparam int EXP_W   = 11;
  localparam int SIG_W   = 53;
  localparam int BIAS    = 1023;
  localparam int EXP_MAX = 2047;

  // Rounding modes; 5..7 fall back to RNE behaviour on overflow.
  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  // fflags bit positions: {NV,DZ,OF,UF,NX}
  localparam int FF_NV = 4;
  localparam int FF_DZ = 3;
  localparam int FF_OF = 2;
  localparam int FF_UF = 1;
  localparam int FF_NX = 0;

  localparam logic [63:0] QNAN     = 64'h7FF8_0000_0000_0000;
  localparam logic [62:0] INF_MAG  = 63'h7FF0_0000_0000_0000;
  localparam logic [62:0] MAXF_MAG = 63'h7FEF_FFFF_FFFF_FFFF;

  typedef struct packed {
    logic              sign;
    logic [12:0]       exp;
    logic [SIG_W-1:0]  sig;
    logic              cout;
    logic              inexact;
    logic              tiny;
    logic [2:0]        rm;
    logic              is_nan;
    logic              is_inf;
    logic              invalid;
    logic              dz;
  } pack_req_t;

  typedef struct packed {
    logic [63:0] result;
    logic [4:0]  fflags;
  } pack_rsp_t;

endpackage

// File: rtl/fp64_pack_core.sv
// Combinational packer: rounded sign/exp/significand plus specials -> binary64 and flags.
module fp64_pack_core
  import fp64_result_packer_pkg::*;
(
  input  pack_req_t req,
  output pack_rsp_t rsp
);

  localparam logic signed [12:0] EXP_MAX_S = 13'sd2047;

  logic signed [12:0] exp_r;
  logic               ovf;
  logic [EXP_W-1:0]   exp_fld;
  logic [51:0]        frac;
  logic [62:0]        ovf_mag;

  // Apply the rounding carry, classify overflow, and pick the final encoding.
  always_comb begin
    exp_r   = $signed(req.exp) + $signed({12'b0, req.cout});
    ovf     = (exp_r >= EXP_MAX_S);
    // exp==0 means subnormal; a rounded-up subnormal lands on exponent 1 via sig[52].
    exp_fld = (req.exp == 13'd0) ? {{(EXP_W-1){1'b0}}, req.sig[52]} : exp_r[EXP_W-1:0];
    // A carry-out leaves the significand at exactly 1.0.
    frac    = req.cout ? 52'd0 : req.sig[51:0];
    case (req.rm)
      RM_RTZ:  ovf_mag = MAXF_MAG;
      RM_RDN:  ovf_mag = req.sign ? INF_MAG : MAXF_MAG;
      RM_RUP:  ovf_mag = req.sign ? MAXF_MAG : INF_MAG;
      default: ovf_mag = INF_MAG;
    endcase

    rsp = '0;
    if (req.is_nan) begin
      rsp.result        = QNAN;
      rsp.fflags[FF_NV] = req.invalid;
    end else if (req.is_inf) begin
      rsp.result        = {req.sign, INF_MAG};
      rsp.fflags[FF_DZ] = req.dz;
    end else if (ovf) begin
      rsp.result        = {req.sign, ovf_mag};
      rsp.fflags[FF_OF] = 1'b1;
      rsp.fflags[FF_UF] = req.tiny & req.inexact;
      rsp.fflags[FF_NX] = 1'b1;
    end else begin
      rsp.result        = {req.sign, exp_fld, frac};
      rsp.fflags[FF_UF] = req.tiny & req.inexact;
      rsp.fflags[FF_NX] = req.inexact;
    end
  end

endmodule

// File: rtl/fp64_result_packer.sv
// Result packer behind the rounder: packs one result per cycle into a 2-entry output FIFO.
module fp64_result_packer
  import fp64_result_packer_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        io_in_valid,
  output logic        io_in_ready,
  input  logic        io_in_sign,
  input  logic [12:0] io_in_exp,
  input  logic [52:0] io_in_sig,
  input  logic        io_in_cout,
  input  logic        io_in_inexact,
  input  logic        io_in_tiny,
  input  logic [2:0]  io_in_rm,
  input  logic        io_in_isNaN,
  input  logic        io_in_isInf,
  input  logic        io_in_invalid,
  input  logic        io_in_dz,
  output logic        io_out_valid,
  input  logic        io_out_ready,
  output logic [63:0] io_out_result,
  output logic [4:0]  io_out_fflags
);

  localparam int DEPTH = 2;

  pack_req_t req;
  pack_rsp_t rsp;
  pack_rsp_t mem [DEPTH];
  logic      head, tail;
  logic [1:0] count;
  logic      push, pop;

  assign req = '{sign: io_in_sign, exp: io_in_exp, sig: io_in_sig, cout: io_in_cout,
                 inexact: io_in_inexact, tiny: io_in_tiny, rm: io_in_rm,
                 is_nan: io_in_isNaN, is_inf: io_in_isInf, invalid: io_in_invalid,
                 dz: io_in_dz};

  fp64_pack_core u_core (
    .req (req),
    .rsp (rsp)
  );

  // Ready depends on registered count only, so no path from io_out_ready.
  assign io_in_ready   = (count != 2'd2);
  assign io_out_valid  = (count != 2'd0);
  assign io_out_result = mem[head].result;
  assign io_out_fflags = mem[head].fflags;
  assign push          = io_in_valid & io_in_ready;
  assign pop           = io_out_valid & io_out_ready;

  // FIFO storage and pointers; reset wipes contents so outputs read 0.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[tail] <= rsp;
        tail      <= ~tail;
      end
      if (pop) head <= ~head;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fp64_result_packer.sv
// Directed bench for fp64_result_packer: packing vectors, specials, backpressure, reset.
module tb_fp64_result_packer;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_in_valid, io_in_ready;
  logic        io_in_sign;
  logic [12:0] io_in_exp;
  logic [52:0] io_in_sig;
  logic        io_in_cout, io_in_inexact, io_in_tiny;
  logic [2:0]  io_in_rm;
  logic        io_in_isNaN, io_in_isInf, io_in_invalid, io_in_dz;
  logic        io_out_valid, io_out_ready;
  logic [63:0] io_out_result;
  logic [4:0]  io_out_fflags;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [52:0] ONE = 53'h10_0000_0000_0000;

  fp64_result_packer dut (
    .clock(clock), .reset(reset),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_in_sign(io_in_sign), .io_in_exp(io_in_exp), .io_in_sig(io_in_sig),
    .io_in_cout(io_in_cout), .io_in_inexact(io_in_inexact), .io_in_tiny(io_in_tiny),
    .io_in_rm(io_in_rm), .io_in_isNaN(io_in_isNaN), .io_in_isInf(io_in_isInf),
    .io_in_invalid(io_in_invalid), .io_in_dz(io_in_dz),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_out_result(io_out_result), .io_out_fflags(io_out_fflags)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic s, input logic [12:0] e, input logic [52:0] sg,
                        input logic co, input logic nx, input logic tn, input logic [2:0] rm,
                        input logic nan, input logic inf, input logic inv, input logic dz);
    io_in_sign = s; io_in_exp = e; io_in_sig = sg; io_in_cout = co;
    io_in_inexact = nx; io_in_tiny = tn; io_in_rm = rm;
    io_in_isNaN = nan; io_in_isInf = inf; io_in_invalid = inv; io_in_dz = dz;
  endtask

  // One transaction through an empty FIFO with io_out_ready=1: visible one edge later, gone the next.
  task automatic send(input string tag, input logic [63:0] er, input logic [4:0] ef);
    io_in_valid = 1'b1;
    step();
    io_in_valid = 1'b0;
    chk({tag, ".vld"}, 64'(io_out_valid), 64'd1);
    chk({tag, ".res"}, io_out_result, er);
    chk({tag, ".ff"},  64'(io_out_fflags), 64'(ef));
    step();
    chk({tag, ".pop"}, 64'(io_out_valid), 64'd0);
  endtask

  initial begin
    reset = 1'b0; io_in_valid = 1'b0; io_out_ready = 1'b1;
    set_in(0, 13'd0, 53'd0, 0, 0, 0, 3'd0, 0, 0, 0, 0);
    step(); step();
    chk("rst.vld", 64'(io_out_valid), 64'd0);
    chk("rst.rdy", 64'(io_in_ready), 64'd1);
    chk("rst.res", io_out_result, 64'd0);
    chk("rst.ff",  64'(io_out_fflags), 64'd0);
    reset = 1'b1;
    step();

    set_in(0, 13'd1023, ONE, 0, 0, 0, 3'd0, 0, 0, 0, 0);
    send("normal", 64'h3FF0_0000_0000_0000, 5'h00);
    set_in(1, 13'd1024, 53'h18_0000_0000_0000, 0, 0, 0, 3'd0, 0, 0, 0, 0);
    send("neg3", 64'hC008_0000_0000_0000, 5'h00);
    set_in(0, 13'd1023, 53'd0, 1, 1, 0, 3'd0, 0, 0, 0, 0);
    send("carry", 64'h4000_0000_0000_0000, 5'h01);
    set_in(1, 13'd2046, ONE, 1, 1, 0, 3'd1, 0, 0, 0, 0);
    send("of_rtz", 64'hFFEF_FFFF_FFFF_FFFF, 5'h05);
    set_in(1, 13'd2046, ONE, 1, 1, 0, 3'd2, 0, 0, 0, 0);
    send("of_rdn", 64'hFFF0_0000_0000_0000, 5'h05);
    set_in(1, 13'd2046, ONE, 1, 1, 0, 3'd3, 0, 0, 0, 0);
    send("of_rup_n", 64'hFFEF_FFFF_FFFF_FFFF, 5'h05);
    set_in(0, 13'd2046, ONE, 1, 1, 0, 3'd3, 0, 0, 0, 0);
    send("of_rup_p", 64'h7FF0_0000_0000_0000, 5'h05);
    set_in(0, 13'd2046, ONE, 1, 1, 0, 3'd2, 0, 0, 0, 0);
    send("of_rdn_p", 64'h7FEF_FFFF_FFFF_FFFF, 5'h05);
    set_in(0, 13'd2047, ONE, 0, 0, 0, 3'd6, 0, 0, 0, 0);
    send("of_rm6", 64'h7FF0_0000_0000_0000, 5'h05);
    set_in(0, 13'd0, ONE, 0, 1, 1, 3'd0, 0, 0, 0, 0);
    send("sub_up", 64'h0010_0000_0000_0000, 5'h03);
    set_in(0, 13'd0, 53'd1, 0, 0, 1, 3'd0, 0, 0, 0, 0);
    send("sub", 64'h0000_0000_0000_0001, 5'h00);
    set_in(1, 13'd5, ONE, 0, 0, 0, 3'd0, 1, 0, 1, 1);
    send("nan", 64'h7FF8_0000_0000_0000, 5'h10);
    set_in(1, 13'd5, ONE, 0, 0, 0, 3'd0, 1, 1, 0, 1);
    send("nan_pri", 64'h7FF8_0000_0000_0000, 5'h00);
    set_in(1, 13'd2046, ONE, 1, 1, 1, 3'd1, 0, 1, 0, 1);
    send("inf_pri", 64'hFFF0_0000_0000_0000, 5'h08);

    // Backpressure: A, B fill the FIFO, C is held off until a slot frees.
    io_out_ready = 1'b0;
    set_in(0, 13'd1023, ONE, 0, 0, 0, 3'd0, 0, 0, 0, 0);
    io_in_valid = 1'b1;
    step();
    chk("bp.rdy1", 64'(io_in_ready), 64'd1);
    chk("bp.resA", io_out_result, 64'h3FF0_0000_0000_0000);
    set_in(0, 13'd1024, ONE, 0, 0, 0, 3'd0, 0, 0, 0, 0);
    step();
    chk("bp.full", 64'(io_in_ready), 64'd0);
    chk("bp.vld",  64'(io_out_valid), 64'd1);
    set_in(0, 13'd1025, ONE, 0, 0, 0, 3'd0, 0, 0, 0, 0);
    step();
    chk("bp.hold", 64'(io_in_ready), 64'd0);
    chk("bp.head", io_out_result, 64'h3FF0_0000_0000_0000);
    io_out_ready = 1'b1;
    step();
    chk("bp.popA", io_out_result, 64'h4000_0000_0000_0000);
    chk("bp.rdy2", 64'(io_in_ready), 64'd1);
    step();
    chk("bp.resC", io_out_result, 64'h4010_0000_0000_0000);
    chk("bp.cnt1v", 64'(io_out_valid), 64'd1);
    chk("bp.cnt1r", 64'(io_in_ready), 64'd1);
    io_in_valid = 1'b0;
    step();
    chk("bp.empty", 64'(io_out_valid), 64'd0);

    // Reset with two results buffered: they must never come out.
    io_out_ready = 1'b0;
    set_in(1, 13'd1023, ONE, 0, 1, 0, 3'd0, 0, 0, 0, 0);
    io_in_valid = 1'b1;
    step(); step();
    io_in_valid = 1'b0;
    chk("mr.full", 64'(io_in_ready), 64'd0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("mr.vld", 64'(io_out_valid), 64'd0);
    chk("mr.rdy", 64'(io_in_ready), 64'd1);
    chk("mr.res", io_out_result, 64'd0);
    chk("mr.ff",  64'(io_out_fflags), 64'd0);
    io_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mr.gone", 64'(io_out_valid), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
